level_flow_ctrl: RTL and testbench
==================================

# level_flow_ctrl

Game-flow controller that drives the black-screen overlay and the rest of the game. It owns the level number and the pig and bird budgets, and decides when a level is cleared, lost or won. It issues the one-cycle `levelChange` pulse and the held `GAMEOVER` level that the overlay consumes, and holds gameplay off for a fixed number of video frames after each level change. It sits between the game-object logic (pig and bird event pulses) and the VGA overlay/display mux.

## Interface
- `NUM_LEVELS`, default 3: number of levels, 1..4.
- `BIRDS_PER_LEVEL`, default 3: birds loaded at each level start, 1..7.
- `BLANK_FRAMES`, default 60: frames of blanking after each `levelChange`, 1..255.

- `clk`, input, 1: system clock.
- `resetN`, input, 1: asynchronous, active-low reset.
- `startOfFrame`, input, 1: one-cycle pulse per video frame.
- `startKey`, input, 1: one-cycle start/restart request, already debounced.
- `pigKilled`, input, 1: one-cycle pulse; a pig was destroyed.
- `birdSettled`, input, 1: one-cycle pulse; a launched bird has finished its flight.
- `levelChange`, output, 1: one-cycle pulse at every level (re)start.
- `GAMEOVER`, output, 1: held high while in `GAME_OVER_ST`.
- `win`, output, 1: held high while in `WIN_ST`.
- `gameActive`, output, 1: high only in `PLAY_ST`.
- `blankActive`, output, 1: high only in `BLANK_ST`.
- `level`, output, 2: current level index, 0-based.
- `pigsLeft`, output, 4: pigs remaining in the current level.
- `birdsLeft`, output, 3: birds remaining in the current level.

## Operation
- States: `IDLE_ST`, `BLANK_ST`, `PLAY_ST`, `GAME_OVER_ST`, `WIN_ST`.
- Level load: `level` gets its target value, `pigsLeft` gets `PIGS_PER_LEVEL[level]`, `birdsLeft` gets `BIRDS_PER_LEVEL`, the frame counter clears, `levelChange` pulses, and the state moves to `BLANK_ST`.
- `IDLE_ST`: on `startKey`, load level 0.
- `BLANK_ST`:
  - Counts `startOfFrame` pulses.
  - On the pulse where the count equals `BLANK_FRAMES`-1, go to `PLAY_ST`.
  - The result is exactly `BLANK_FRAMES` frames counted in this state.
  - `pigKilled` and `birdSettled` are ignored.
- `PLAY_ST`:
  - `pigKilled` decrements `pigsLeft`, saturating at 0.
  - `birdSettled` decrements `birdsLeft`, saturating at 0.
- Level cleared: `pigKilled` arrives with `pigsLeft`==1.
  - If `level`==`NUM_LEVELS`-1, go to `WIN_ST`.
  - Otherwise load `level`+1.
- Level lost: `birdSettled` arrives with `birdsLeft`==1, and the level is not cleared in the same cycle. Go to `GAME_OVER_ST`.
- Simultaneous last `pigKilled` and last `birdSettled`: the clear wins and the level advances or the game is won. Both counters show their decremented values until the reload.
- `GAME_OVER_ST` and `WIN_ST`: the counters freeze. `startKey` loads level 0, and `GAMEOVER`/`win` drop in the same cycle that `levelChange` rises.
- `startKey` in `BLANK_ST` or `PLAY_ST` is ignored.
- Event pulses in `IDLE_ST`, `GAME_OVER_ST` and `WIN_ST` are ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state `IDLE_ST`.
  - `level`=0, `pigsLeft`=0, `birdsLeft`=0.
  - `levelChange`, `GAMEOVER`, `win`, `gameActive` and `blankActive` all 0.
  - frame counter 0.
- Latency from an event sampled at edge N:
  - `levelChange`, `blankActive`, the new `level` and the new counts are visible after edge N, i.e. in cycle N+1.
  - `levelChange` falls after edge N+1.
- A `startOfFrame` sampled on the same edge as the triggering event is not counted. Counting starts with the first `startOfFrame` sampled while in `BLANK_ST`.
- `gameActive` rises and `blankActive` falls on the edge that samples the final counted `startOfFrame`.
- Counter decrements are visible one cycle after the sampled pulse.
- Reset asserted mid-operation, including mid-`BLANK_ST`: all state returns immediately to the reset values; no pulse is emitted on release.
- The frame counter is 8 bits, and no counter wraps.

## Structure
- Package `level_flow_pkg` holds:
  - the state enum typedef.
  - `PIGS_PER_LEVEL` constant array, {3,4,5,6}, with each entry ≤15.
  - the width constants for `level`, `pigsLeft`, `birdsLeft` and the frame counter.
- The only sub-module is `frame_blank_timer`.
  - Ports: clear, enable, `startOfFrame`, done; parameter `BLANK_FRAMES`.
  - It counts frames; the FSM uses its done output to leave `BLANK_ST`.

## Test plan
Bench parameters: `BLANK_FRAMES`=4, `BIRDS_PER_LEVEL`=3, `NUM_LEVELS`=3.
- Reset release with no stimulus: all outputs 0 and `level`=0 for 100 cycles. `pigKilled` pulses applied during this time produce no change.
- `startKey` pulse:
  - `levelChange` is high for exactly 1 cycle and `blankActive` is 1.
  - After the 4th `startOfFrame`, `gameActive`=1, `pigsLeft`=3, `birdsLeft`=3.
  - A `startOfFrame` on the `startKey` edge is not counted.
- Three `pigKilled` pulses in level 0: `level`=1, `levelChange` pulse, `pigsLeft`=4, `birdsLeft`=3, `blankActive`=1.
- Two `pigKilled` and three `birdSettled` in level 0: `GAMEOVER`=1 held, `pigsLeft`=1. A later `startKey` gives `GAMEOVER`=0, a `levelChange` pulse and `level`=0.
- In level 0 with `pigsLeft`=1 and `birdsLeft`=1, `pigKilled` and `birdSettled` in the same cycle: `level`=1 and `GAMEOVER` stays 0.
- Further scenarios:
  - Clearing level 2 gives `win`=1.
  - Asserting `resetN` low during the 2nd blank frame returns to `IDLE_ST` with all outputs 0.

Source files
------------

// File: rtl/level_flow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : level_flow_pkg
// Description : Shared types and constants for the level flow controller:
//               FSM state encoding, datapath widths and the per-level pig
//               budget table.
// Revision    : 1.0 - initial release
// ============================================================================
package level_flow_pkg;

    typedef enum logic [2:0] {
        IDLE_ST      = 3'd0,
        BLANK_ST     = 3'd1,
        PLAY_ST      = 3'd2,
        GAME_OVER_ST = 3'd3,
        WIN_ST       = 3'd4
    } state_t;

    localparam int LEVEL_W = 2;
    localparam int PIGS_W  = 4;
    localparam int BIRDS_W = 3;
    localparam int FRAME_W = 8;

    // Entry [i] is the pig count loaded for level i.
    localparam logic [3:0][PIGS_W-1:0] PIGS_PER_LEVEL = {4'd6, 4'd5, 4'd4, 4'd3};

    function automatic logic [PIGS_W-1:0] pigs_for_level(input logic [LEVEL_W-1:0] lvl);
        return PIGS_PER_LEVEL[lvl];
    endfunction

endpackage
`default_nettype wire

// File: rtl/level_flow_ctrl_frame_blank_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_blank_timer
// Description : Counts startOfFrame pulses while enabled. done is a
//               combinational flag raised on the pulse that completes
//               BLANK_FRAMES frames, so the controller can leave blanking on
//               that same edge.
// Ports       : clk, resetN (async, active-low)
//               clear        - zero the frame count (level load)
//               enable       - count only while high (blanking state)
//               startOfFrame - one-cycle frame pulse
//               done         - final counted frame is being sampled
// Revision    : 1.0 - initial release
// ============================================================================
module frame_blank_timer
    import level_flow_pkg::*;
#(
    parameter int unsigned BLANK_FRAMES = 60
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic enable,
    input  logic startOfFrame,
    output logic done
);

    localparam logic [FRAME_W-1:0] LAST_COUNT = FRAME_W'(BLANK_FRAMES - 1);

    logic [FRAME_W-1:0] count_q;
    logic [FRAME_W-1:0] count_d;

    assign done = enable && startOfFrame && (count_q == LAST_COUNT);

    // The count holds at LAST_COUNT once done fires; it never wraps and is
    // only zeroed by the next level load.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && startOfFrame && !done) begin
            count_d = count_q + FRAME_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/level_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : level_flow_ctrl
// Description : Game-flow controller. Owns the level index and the pig/bird
//               budgets, blanks gameplay for BLANK_FRAMES frames after every
//               level (re)start, and decides clear / loss / win.
// Ports       : clk, resetN (async, active-low)
//               startOfFrame - frame pulse
//               startKey     - start/restart request (debounced pulse)
//               pigKilled    - pig destroyed pulse
//               birdSettled  - bird finished flight pulse
//               levelChange  - one-cycle pulse at each level load
//               GAMEOVER     - held in game-over state
//               win          - held in win state
//               gameActive   - high during play
//               blankActive  - high during blanking
//               level        - 0-based level index
//               pigsLeft     - pigs remaining
//               birdsLeft    - birds remaining
// Revision    : 1.0 - initial release
// ============================================================================
module level_flow_ctrl
    import level_flow_pkg::*;
#(
    parameter int unsigned NUM_LEVELS      = 3,
    parameter int unsigned BIRDS_PER_LEVEL = 3,
    parameter int unsigned BLANK_FRAMES    = 60
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               startKey,
    input  logic               pigKilled,
    input  logic               birdSettled,
    output logic               levelChange,
    output logic               GAMEOVER,
    output logic               win,
    output logic               gameActive,
    output logic               blankActive,
    output logic [LEVEL_W-1:0] level,
    output logic [PIGS_W-1:0]  pigsLeft,
    output logic [BIRDS_W-1:0] birdsLeft
);

    localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [BIRDS_W-1:0] BIRDS_START = BIRDS_W'(BIRDS_PER_LEVEL);

    state_t               state_q,        state_d;
    logic [LEVEL_W-1:0]   level_q,        level_d;
    logic [PIGS_W-1:0]    pigs_left_q,    pigs_left_d;
    logic [BIRDS_W-1:0]   birds_left_q,   birds_left_d;
    logic                 level_change_q, level_change_d;
    logic                 gameover_q,     gameover_d;
    logic                 win_q,          win_d;
    logic                 game_active_q,  game_active_d;
    logic                 blank_active_q, blank_active_d;

    logic                 w_load;
    logic [LEVEL_W-1:0]   w_load_level;
    logic                 w_timer_done;

    frame_blank_timer #(
        .BLANK_FRAMES (BLANK_FRAMES)
    ) u_blank_timer (
        .clk          (clk),
        .resetN       (resetN),
        .clear        (w_load),
        .enable       (state_q == BLANK_ST),
        .startOfFrame (startOfFrame),
        .done         (w_timer_done)
    );

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        pigs_left_d  = pigs_left_q;
        birds_left_d = birds_left_q;
        w_load       = 1'b0;
        w_load_level = '0;

        case (state_q)
            IDLE_ST: begin
                if (startKey) begin
                    w_load = 1'b1;
                end
            end

            BLANK_ST: begin
                if (w_timer_done) begin
                    state_d = PLAY_ST;
                end
            end

            PLAY_ST: begin
                if (pigKilled && (pigs_left_q != '0)) begin
                    pigs_left_d = pigs_left_q - PIGS_W'(1);
                end
                if (birdSettled && (birds_left_q != '0)) begin
                    birds_left_d = birds_left_q - BIRDS_W'(1);
                end
                // A clear takes priority over a loss in the same cycle; in
                // the win case the decremented counts remain on display.
                if (pigKilled && (pigs_left_q == PIGS_W'(1))) begin
                    if (level_q == LAST_LEVEL) begin
                        state_d = WIN_ST;
                    end else begin
                        w_load       = 1'b1;
                        w_load_level = level_q + LEVEL_W'(1);
                    end
                end else if (birdSettled && (birds_left_q == BIRDS_W'(1))) begin
                    state_d = GAME_OVER_ST;
                end
            end

            GAME_OVER_ST, WIN_ST: begin
                if (startKey) begin
                    w_load = 1'b1;
                end
            end

            default: begin
                state_d = IDLE_ST;
            end
        endcase

        if (w_load) begin
            state_d      = BLANK_ST;
            level_d      = w_load_level;
            pigs_left_d  = pigs_for_level(w_load_level);
            birds_left_d = BIRDS_START;
        end

        // Status flags are derived from the next state so they change on the
        // same edge as the state register.
        level_change_d = w_load;
        gameover_d     = (state_d == GAME_OVER_ST);
        win_d          = (state_d == WIN_ST);
        game_active_d  = (state_d == PLAY_ST);
        blank_active_d = (state_d == BLANK_ST);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE_ST;
            level_q        <= '0;
            pigs_left_q    <= '0;
            birds_left_q   <= '0;
            level_change_q <= 1'b0;
            gameover_q     <= 1'b0;
            win_q          <= 1'b0;
            game_active_q  <= 1'b0;
            blank_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            pigs_left_q    <= pigs_left_d;
            birds_left_q   <= birds_left_d;
            level_change_q <= level_change_d;
            gameover_q     <= gameover_d;
            win_q          <= win_d;
            game_active_q  <= game_active_d;
            blank_active_q <= blank_active_d;
        end
    end

    assign levelChange = level_change_q;
    assign GAMEOVER    = gameover_q;
    assign win         = win_q;
    assign gameActive  = game_active_q;
    assign blankActive = blank_active_q;
    assign level       = level_q;
    assign pigsLeft    = pigs_left_q;
    assign birdsLeft   = birds_left_q;

endmodule
`default_nettype wire

// File: tb/tb_level_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_level_flow_ctrl
// Description : Self-checking bench for level_flow_ctrl. Each scenario task
//               queues stimulus with its expected output word; the expected
//               word moves to a scoreboard queue when the stimulus is driven
//               and is popped and compared one edge later.
//               Output word: {levelChange, GAMEOVER, win, gameActive,
//               blankActive, level[1:0], pigsLeft[3:0], birdsLeft[2:0]}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level_flow_ctrl;

    logic       clk          = 1'b0;
    logic       resetN       = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       startKey     = 1'b0;
    logic       pigKilled    = 1'b0;
    logic       birdSettled  = 1'b0;
    logic       levelChange;
    logic       GAMEOVER;
    logic       win;
    logic       gameActive;
    logic       blankActive;
    logic [1:0] level;
    logic [3:0] pigsLeft;
    logic [2:0] birdsLeft;

    level_flow_ctrl #(
        .NUM_LEVELS      (3),
        .BIRDS_PER_LEVEL (3),
        .BLANK_FRAMES    (4)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .startKey     (startKey),
        .pigKilled    (pigKilled),
        .birdSettled  (birdSettled),
        .levelChange  (levelChange),
        .GAMEOVER     (GAMEOVER),
        .win          (win),
        .gameActive   (gameActive),
        .blankActive  (blankActive),
        .level        (level),
        .pigsLeft     (pigsLeft),
        .birdsLeft    (birdsLeft)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sk;
        logic        pk;
        logic        bs;
        logic        sof;
        logic [13:0] exp;
    } vec_t;

    vec_t        stim_q[$];
    logic [13:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [13:0] E(input logic lc, input logic go, input logic wn,
                                      input logic ga, input logic ba, input logic [1:0] lvl,
                                      input logic [3:0] p, input logic [2:0] b);
        return {lc, go, wn, ga, ba, lvl, p, b};
    endfunction

    function automatic logic [13:0] observed();
        return {levelChange, GAMEOVER, win, gameActive, blankActive, level, pigsLeft, birdsLeft};
    endfunction

    task automatic add(input logic sk, input logic pk, input logic bs, input logic sof,
                       input logic [13:0] e);
        vec_t v;
        v.sk = sk; v.pk = pk; v.bs = bs; v.sof = sof; v.exp = e;
        stim_q.push_back(v);
    endtask

    task automatic idle_inputs();
        startKey = 1'b0; pigKilled = 1'b0; birdSettled = 1'b0; startOfFrame = 1'b0;
    endtask

    // Reset release, 100 cycles of event pulses (no startKey): all zero.
    task automatic test_reset();
        vec_t v; logic [13:0] got, want; int idx = 0;
        resetN = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        got = observed(); n_vec++;
        if (got !== 14'h0) begin
            n_err++; $display("FAIL reset_held got=%h want=%h", got, 14'h0);
        end
        resetN = 1'b1;
        for (int i = 0; i < 100; i++)
            add(1'b0, (i % 10) == 3, (i % 13) == 5, (i % 5) == 0, E(0,0,0,0,0,2'd0,4'd0,3'd0));
        while (stim_q.size() != 0) begin
            v = stim_q.pop_front();
            startKey = v.sk; pigKilled = v.pk; birdSettled = v.bs; startOfFrame = v.sof;
            exp_q.push_back(v.exp);
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL reset_idle[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
        idle_inputs();
    endtask

    // Start, blanking for 4 frames (SOF on start edge not counted), ignored
    // events and startKey during blank/play.
    task automatic test_start();
        vec_t v; logic [13:0] got, want; int idx = 0;
        add(1, 0, 0, 1, E(1,0,0,0,1,2'd0,4'd3,3'd3));
        add(0, 0, 0, 0, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        add(0, 1, 1, 0, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        add(0, 0, 0, 1, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        add(1, 0, 0, 1, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        add(0, 0, 0, 1, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        add(0, 0, 0, 0, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        add(0, 0, 0, 1, E(0,0,0,1,0,2'd0,4'd3,3'd3));
        add(0, 0, 0, 1, E(0,0,0,1,0,2'd0,4'd3,3'd3));
        add(1, 0, 0, 0, E(0,0,0,1,0,2'd0,4'd3,3'd3));
        while (stim_q.size() != 0) begin
            v = stim_q.pop_front();
            startKey = v.sk; pigKilled = v.pk; birdSettled = v.bs; startOfFrame = v.sof;
            exp_q.push_back(v.exp);
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL start[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
        idle_inputs();
    endtask

    // Level 0: two pigs, three birds -> game over; restart back to level 0.
    task automatic test_game_over();
        vec_t v; logic [13:0] got, want; int idx = 0;
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd0,4'd2,3'd3));
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd0,4'd1,3'd3));
        add(0, 0, 1, 0, E(0,0,0,1,0,2'd0,4'd1,3'd2));
        add(0, 0, 1, 0, E(0,0,0,1,0,2'd0,4'd1,3'd1));
        add(0, 0, 1, 0, E(0,1,0,0,0,2'd0,4'd1,3'd0));
        add(0, 1, 1, 1, E(0,1,0,0,0,2'd0,4'd1,3'd0));
        add(0, 0, 0, 0, E(0,1,0,0,0,2'd0,4'd1,3'd0));
        add(1, 0, 0, 0, E(1,0,0,0,1,2'd0,4'd3,3'd3));
        add(0, 0, 0, 0, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        add(0, 0, 0, 1, E(0,0,0,1,0,2'd0,4'd3,3'd3));
        while (stim_q.size() != 0) begin
            v = stim_q.pop_front();
            startKey = v.sk; pigKilled = v.pk; birdSettled = v.bs; startOfFrame = v.sof;
            exp_q.push_back(v.exp);
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL game_over[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
        idle_inputs();
    endtask

    // Level 0 with one pig and one bird left: simultaneous last events -> clear.
    task automatic test_simultaneous();
        vec_t v; logic [13:0] got, want; int idx = 0;
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd0,4'd2,3'd3));
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd0,4'd1,3'd3));
        add(0, 0, 1, 0, E(0,0,0,1,0,2'd0,4'd1,3'd2));
        add(0, 0, 1, 0, E(0,0,0,1,0,2'd0,4'd1,3'd1));
        add(0, 1, 1, 0, E(1,0,0,0,1,2'd1,4'd4,3'd3));
        add(0, 0, 0, 0, E(0,0,0,0,1,2'd1,4'd4,3'd3));
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, E(0,0,0,0,1,2'd1,4'd4,3'd3));
        add(0, 0, 0, 1, E(0,0,0,1,0,2'd1,4'd4,3'd3));
        while (stim_q.size() != 0) begin
            v = stim_q.pop_front();
            startKey = v.sk; pigKilled = v.pk; birdSettled = v.bs; startOfFrame = v.sof;
            exp_q.push_back(v.exp);
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL simultaneous[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
        idle_inputs();
    endtask

    // Level 1: back-to-back pig kills clear the level into level 2.
    task automatic test_clear_level();
        vec_t v; logic [13:0] got, want; int idx = 0;
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd1,4'd3,3'd3));
        add(0, 0, 1, 0, E(0,0,0,1,0,2'd1,4'd3,3'd2));
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd1,4'd2,3'd2));
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd1,4'd1,3'd2));
        add(0, 1, 0, 0, E(1,0,0,0,1,2'd2,4'd5,3'd3));
        add(0, 0, 0, 0, E(0,0,0,0,1,2'd2,4'd5,3'd3));
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, E(0,0,0,0,1,2'd2,4'd5,3'd3));
        add(0, 0, 0, 1, E(0,0,0,1,0,2'd2,4'd5,3'd3));
        while (stim_q.size() != 0) begin
            v = stim_q.pop_front();
            startKey = v.sk; pigKilled = v.pk; birdSettled = v.bs; startOfFrame = v.sof;
            exp_q.push_back(v.exp);
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL clear_level[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
        idle_inputs();
    endtask

    // Level 2 cleared -> win held, events ignored, startKey restarts.
    task automatic test_win();
        vec_t v; logic [13:0] got, want; int idx = 0;
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd2,4'd4,3'd3));
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd2,4'd3,3'd3));
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd2,4'd2,3'd3));
        add(0, 1, 0, 0, E(0,0,0,1,0,2'd2,4'd1,3'd3));
        add(0, 1, 0, 0, E(0,0,1,0,0,2'd2,4'd0,3'd3));
        add(0, 1, 1, 1, E(0,0,1,0,0,2'd2,4'd0,3'd3));
        add(1, 0, 0, 1, E(1,0,0,0,1,2'd0,4'd3,3'd3));
        add(0, 0, 0, 0, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        while (stim_q.size() != 0) begin
            v = stim_q.pop_front();
            startKey = v.sk; pigKilled = v.pk; birdSettled = v.bs; startOfFrame = v.sof;
            exp_q.push_back(v.exp);
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL win[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
        idle_inputs();
    endtask

    // Reset during the 2nd blank frame: immediate return to reset values,
    // no pulse on release, and a fresh start needs the full 4 frames again.
    task automatic test_reset_mid_blank();
        vec_t v; logic [13:0] got, want; int idx = 0;
        add(0, 0, 0, 1, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        while (stim_q.size() != 0) begin
            v = stim_q.pop_front();
            startKey = v.sk; pigKilled = v.pk; birdSettled = v.bs; startOfFrame = v.sof;
            exp_q.push_back(v.exp);
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL mid_reset_pre[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
        resetN = 1'b0;
        #2;
        got = observed(); n_vec++;
        if (got !== 14'h0) begin
            n_err++; $display("FAIL mid_reset_async got=%h want=%h", got, 14'h0);
        end
        @(posedge clk); #1;
        resetN = 1'b1;
        idx = 0;
        for (int i = 0; i < 6; i++) add(0, 0, 0, (i % 2) == 0, E(0,0,0,0,0,2'd0,4'd0,3'd0));
        add(1, 0, 0, 0, E(1,0,0,0,1,2'd0,4'd3,3'd3));
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1, E(0,0,0,0,1,2'd0,4'd3,3'd3));
        add(0, 0, 0, 1, E(0,0,0,1,0,2'd0,4'd3,3'd3));
        while (stim_q.size() != 0) begin
            v = stim_q.pop_front();
            startKey = v.sk; pigKilled = v.pk; birdSettled = v.bs; startOfFrame = v.sof;
            exp_q.push_back(v.exp);
            @(posedge clk); #1;
            got = observed(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL mid_reset_post[%0d] got=%h want=%h", idx, got, want);
            end
            idx++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_start();
        test_game_over();
        test_simultaneous();
        test_clear_level();
        test_win();
        test_reset_mid_blank();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
